sccb_req_scheduler: RTL and testbench

Shares one SCCB/I2C transaction engine (GO/WR/END/ACK handshake, 24-bit {ID, sub-address, data} word) among several requesters, e.g. the boot-time register sequencer, auto-exposure writes and a host debug port. It applies round-robin arbitration, packs the selected request into the engine word and runs the GO/END handshake. It retries NACKed transfers a bounded number of times and returns per-requester done or error pulses plus read data. It sits between the camera-config requesters and the I2C controller, clocked on the system clock and stepped by the controller's data-change strobe.

---
 rtl/sccb_pkg.sv | 20 ++
 rtl/sccb_req_scheduler_rr_pick.sv | 28 ++
 rtl/sccb_req_scheduler.sv | 157 +++++++++++++++
 tb/tb_sccb_req_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB scheduler state type, default ID and word packing
package sccb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } sccb_state_e;

  localparam logic [7:0] SCCB_DEV_ID = 8'h42;

  // Engine word layout: {slave ID, sub-address, data}
  function automatic logic [23:0] pack_word(input logic [7:0] id,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return {id, addr, data};
  endfunction

endpackage

// File: rtl/sccb_req_scheduler_rr_pick.sv
// rtl/sccb_req_scheduler_rr_pick.sv - combinational round-robin selector
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  int cand;

  // Scan from the farthest offset down so the first set bit at or after ptr wins
  always_comb begin
    cand  = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/sccb_req_scheduler.sv
// rtl/sccb_req_scheduler.sv - round-robin SCCB requester scheduler with NACK retry
module sccb_req_scheduler
  import sccb_pkg::*;
#(
  parameter int         NUM_REQ   = 3,
  parameter int         RETRY_MAX = 3,
  parameter logic [7:0] DEV_ID    = SCCB_DEV_ID
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 I2C_EN,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [NUM_REQ-1:0]   REQ_WR,
  input  logic [8*NUM_REQ-1:0] REQ_ADDR,
  input  logic [8*NUM_REQ-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]   DONE,
  output logic [NUM_REQ-1:0]   ERR,
  output logic [7:0]           RDATA,
  output logic                 BUSY,
  output logic                 GO,
  output logic                 WR,
  output logic [23:0]          WDATA,
  input  logic                 END,
  input  logic                 ACK,
  input  logic [7:0]           I2C_RDATA
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [AW-1:0] ATT_LAST = AW'(RETRY_MAX);
  localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

  sccb_state_e          state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [AW-1:0]        att_q, att_d;
  logic                 go_q, go_d;
  logic                 wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic [23:0]          wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        ptr_after;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The requester just served drops to lowest priority for the next grant
  assign ptr_after = (idx_q == IDX_LAST) ? '0 : idx_q + PW'(1);

  // Next-state and output decode; the FSM only steps on the SCL falling-edge strobe
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    att_d   = att_q;
    go_d    = go_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = '0;
    if (I2C_EN) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            idx_d   = pick_idx;
            wr_d    = REQ_WR[pick_idx];
            wdata_d = pack_word(DEV_ID, REQ_ADDR[{pick_idx, 3'b000} +: 8],
                                REQ_WDATA[{pick_idx, 3'b000} +: 8]);
            go_d    = 1'b1;
            busy_d  = 1'b1;
            att_d   = '0;
            state_d = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!END) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (END) begin
            go_d = 1'b0;
            if (!ACK) begin
              done_d[idx_q] = 1'b1;
              if (!wr_q) rdata_d = I2C_RDATA;
              ptr_d   = ptr_after;
              state_d = ST_GAP;
            end else if (att_q != ATT_LAST) begin
              att_d   = att_q + AW'(1);
              go_d    = 1'b1;
              state_d = ST_LAUNCH;
            end else begin
              err_d[idx_q] = 1'b1;
              ptr_d   = ptr_after;
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any transfer without pulses
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      att_q   <= '0;
      go_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      att_q   <= att_d;
      go_q    <= go_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign BUSY  = busy_q;
  assign GO    = go_q;
  assign WR    = wr_q;
  assign WDATA = wdata_q;

endmodule

// File: tb/tb_sccb_req_scheduler.sv
// tb/tb_sccb_req_scheduler.sv - self-checking bench for sccb_req_scheduler
module tb_sccb_req_scheduler;

  localparam int N     = 3;
  localparam int RETRY = 3;

  logic           iCLK = 1'b0;
  logic           iRST_N = 1'b0;
  logic           I2C_EN = 1'b0;
  logic [N-1:0]   REQ = '0;
  logic [N-1:0]   REQ_WR = '0;
  logic [8*N-1:0] REQ_ADDR = '0;
  logic [8*N-1:0] REQ_WDATA = '0;
  logic           END = 1'b1;
  logic           ACK = 1'b0;
  logic [7:0]     I2C_RDATA = '0;
  logic [N-1:0]   DONE, ERR;
  logic [7:0]     RDATA;
  logic           BUSY, GO, WR;
  logic [23:0]    WDATA;

  sccb_req_scheduler #(.NUM_REQ(N), .RETRY_MAX(RETRY), .DEV_ID(8'h42)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .I2C_EN(I2C_EN), .REQ(REQ), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .BUSY(BUSY), .GO(GO), .WR(WR), .WDATA(WDATA),
    .END(END), .ACK(ACK), .I2C_RDATA(I2C_RDATA)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: one outstanding transaction record plus the served-last pointer
  logic        m_go, m_wr, m_busy;
  logic [23:0] m_word;
  logic [N-1:0] m_done, m_err;
  logic [7:0]  m_rdata;
  int          m_ptr, m_owner, m_tries;
  bit          m_started, m_closing;

  // Observed events
  int          grants_n = 0, fin_n = 0, eng_starts = 0;
  int          done_cnt[N], err_cnt[N];
  logic [23:0] grant_word[$];
  logic        grant_wr[$];
  int          fin_idx[$];
  logic [7:0]  rdata_at_done = '0;
  logic        busy_prev = 1'b0;

  // Engine emulation
  bit          e_busy = 0, e_cool = 0, rand_mode = 0;
  int          e_cnt = 0, e_len = -1, nack_left = 0, en_wait = 0;
  logic [7:0]  e_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_go = 0; m_wr = 0; m_busy = 0; m_word = '0; m_done = '0; m_err = '0;
    m_rdata = '0; m_ptr = 0; m_owner = 0; m_tries = 0; m_started = 0; m_closing = 0;
  endtask

  task automatic model_step();
    bit found;
    int j;
    m_done = '0;
    m_err  = '0;
    found  = 0;
    if (!I2C_EN) return;
    if (m_closing) begin
      m_closing = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && REQ[j]) begin
          found = 1;
          m_owner = j;
        end
      end
      if (found) begin
        m_wr = REQ_WR[m_owner];
        m_word = {8'h42, REQ_ADDR[8*m_owner +: 8], REQ_WDATA[8*m_owner +: 8]};
        m_go = 1; m_busy = 1; m_tries = 0; m_started = 0;
      end
    end else if (!m_started) begin
      if (!END) m_started = 1;
    end else if (END) begin
      if (!ACK) begin
        m_done[m_owner] = 1'b1;
        if (!m_wr) m_rdata = I2C_RDATA;
        m_ptr = (m_owner + 1) % N;
        m_closing = 1; m_go = 0;
      end else if (m_tries < RETRY) begin
        m_tries++;
        m_started = 0;
      end else begin
        m_err[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % N;
        m_closing = 1; m_go = 0;
      end
    end
  endtask

  task automatic engine_step();
    if (!I2C_EN) return;
    if (e_busy) begin
      if (e_cnt == 0) begin
        e_busy = 0; e_cool = 1; END = 1'b1;
        if (rand_mode) begin
          ACK = ($urandom_range(0, 3) == 0);
          I2C_RDATA = 8'($urandom);
        end else begin
          ACK = (nack_left > 0);
          if (nack_left > 0) nack_left--;
          I2C_RDATA = e_rd;
        end
      end else e_cnt--;
    end else if (e_cool) begin
      e_cool = 0;
    end else if (m_go) begin
      e_busy = 1; END = 1'b0; eng_starts++;
      e_cnt = (e_len >= 0) ? e_len : int'($urandom_range(0, 2));
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
    if (iRST_N) begin
      model_step();
      check("cycle_outputs", {GO, WR, WDATA, DONE, ERR, RDATA, BUSY},
            {m_go, m_wr, m_word, m_done, m_err, m_rdata, m_busy});
      check("pulse_onehot", ($countones({DONE, ERR}) <= 1), 1);
      if (BUSY && !busy_prev) begin
        grants_n++;
        grant_word.push_back(WDATA);
        grant_wr.push_back(WR);
      end
      for (int i = 0; i < N; i++) begin
        if (DONE[i]) begin done_cnt[i]++; fin_n++; fin_idx.push_back(i); rdata_at_done = RDATA; end
        if (ERR[i]) begin err_cnt[i]++; fin_n++; fin_idx.push_back(i); end
      end
      engine_step();
    end
    busy_prev = BUSY;
    if (en_wait == 0) begin I2C_EN = 1'b1; en_wait = $urandom_range(1, 3); end
    else begin I2C_EN = 1'b0; en_wait--; end
    if (rand_mode) begin
      REQ = N'($urandom & $urandom);
      REQ_WR = N'($urandom);
      REQ_ADDR = (8*N)'($urandom);
      REQ_WDATA = (8*N)'($urandom);
    end
  endtask

  task automatic wait_grant(input int target);
    int b = 0;
    while (grants_n < target && b < 400) begin step(); b++; end
    check("grant_in_time", grants_n >= target, 1);
  endtask

  task automatic wait_fin(input int target);
    int b = 0;
    while (fin_n < target && b < 600) begin step(); b++; end
    check("finish_in_time", fin_n >= target, 1);
  endtask

  task automatic do_reset();
    #2;
    iRST_N = 1'b0;
    #1;
    check("rst_go_busy", {GO, BUSY}, 0);
    check("rst_pulses", {DONE, ERR}, 0);
    model_reset();
    e_busy = 0; e_cool = 0; END = 1'b1; ACK = 1'b0;
    repeat (3) step();
    iRST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int g0, f0, s0, d0, e0, fi0, b;
    logic [23:0] w;
    for (int i = 0; i < N; i++) begin done_cnt[i] = 0; err_cnt[i] = 0; end
    model_reset();
    #2;
    check("reset_values", {GO, WR, WDATA, DONE, ERR, RDATA, BUSY}, 0);
    repeat (2) step();
    iRST_N = 1'b1;

    // Single write from requester 1
    REQ_WR = 3'b111; REQ_ADDR = {8'h22, 8'h12, 8'h20}; REQ_WDATA = {8'h02, 8'h80, 8'h01};
    g0 = grants_n; f0 = fin_n; REQ = 3'b010;
    wait_grant(g0 + 1);
    check("wr_word", grant_word[g0], 24'h421280);
    check("wr_dir", grant_wr[g0], 1);
    wait_fin(f0 + 1); REQ = '0; repeat (12) step();
    check("wr_done1", done_cnt[1], 1);
    check("wr_no_err", err_cnt[0] + err_cnt[1] + err_cnt[2], 0);
    check("wr_busy_low", BUSY, 0);
    g0 = grants_n; f0 = fin_n; REQ = 3'b111;
    wait_grant(g0 + 1);
    w = grant_word[g0];
    check("ptr_after_req1", w[15:8], 8'h22);
    wait_fin(f0 + 1); REQ = '0; repeat (12) step();

    // Contention from reset: 0,1,2,0
    do_reset();
    REQ_ADDR = {8'h32, 8'h31, 8'h30};
    g0 = grants_n; f0 = fin_n; fi0 = fin_idx.size(); REQ = 3'b111;
    wait_grant(g0 + 4);
    for (int k = 0; k < 4; k++) begin
      w = grant_word[g0 + k];
      check($sformatf("cont_grant%0d", k), w[15:8], 8'h30 + 8'(k % 3));
    end
    for (int k = 0; k < 3; k++) check($sformatf("cont_done%0d", k), fin_idx[fi0 + k], k);
    REQ = '0; wait_fin(f0 + 4); repeat (12) step();

    // Read on requester 2
    REQ_WR = 3'b011; REQ_ADDR[23:16] = 8'h0A; e_rd = 8'h76;
    g0 = grants_n; f0 = fin_n; d0 = done_cnt[2]; REQ = 3'b100;
    wait_grant(g0 + 1);
    check("rd_dir", grant_wr[g0], 0);
    wait_fin(f0 + 1); REQ = '0;
    check("rd_done2", done_cnt[2] - d0, 1);
    check("rd_data_at_done", rdata_at_done, 8'h76);
    repeat (30) step();
    check("rd_held", RDATA, 8'h76);

    // Two NACKs then ACK
    REQ_WR = 3'b111; nack_left = 2;
    s0 = eng_starts; d0 = done_cnt[0]; e0 = err_cnt[0]; f0 = fin_n; REQ = 3'b001;
    wait_fin(f0 + 1); REQ = '0; repeat (12) step();
    check("nack2_attempts", eng_starts - s0, 3);
    check("nack2_done", done_cnt[0] - d0, 1);
    check("nack2_no_err", err_cnt[0] - e0, 0);

    // Four NACKs exhaust the retries
    nack_left = 4;
    s0 = eng_starts; d0 = done_cnt[0]; e0 = err_cnt[0]; f0 = fin_n; REQ = 3'b001;
    wait_fin(f0 + 1); REQ = '0; repeat (12) step();
    check("nack4_attempts", eng_starts - s0, 4);
    check("nack4_err", err_cnt[0] - e0, 1);
    check("nack4_no_done", done_cnt[0] - d0, 0);
    check("rd_held_after_writes", RDATA, 8'h76);

    // Request dropped and fields changed mid-transfer
    REQ_ADDR[15:8] = 8'h55; REQ_WDATA[15:8] = 8'h66;
    g0 = grants_n; f0 = fin_n; d0 = done_cnt[1]; REQ = 3'b010;
    wait_grant(g0 + 1);
    step();
    REQ = '0; REQ_ADDR[15:8] = 8'hAA; REQ_WDATA[15:8] = 8'hBB;
    wait_fin(f0 + 1);
    check("drop_word", WDATA, 24'h425566);
    repeat (12) step();
    check("drop_done_once", done_cnt[1] - d0, 1);

    // Reset while the engine is transferring
    e_len = 6; g0 = grants_n; REQ = 3'b010;
    wait_grant(g0 + 1);
    b = 0;
    while (END !== 1'b0 && b < 100) begin step(); b++; end
    check("engine_started", END, 0);
    repeat (4) step();
    f0 = fin_n;
    do_reset();
    e_len = -1; REQ_ADDR = {8'h42, 8'h41, 8'h40}; REQ = 3'b111;
    check("rst_no_pulse", fin_n - f0, 0);
    g0 = grants_n; f0 = fin_n;
    wait_grant(g0 + 1);
    w = grant_word[g0];
    check("rst_next_grant0", w[15:8], 8'h40);
    REQ = '0; wait_fin(f0 + 1); repeat (12) step();

    // Randomized traffic against the reference
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0; REQ = '0;
    repeat (80) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
